ex_mul_seq: RTL and testbench

//   Multi-cycle sequencer for EX-stage multiply (alu_op 4'b1011). It replaces the

---
 rtl/ex_mul_seq.sv | 91 +++++++++
 tb/tb_ex_mul_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_seq.sv
// EX-stage multi-cycle multiplier: radix-2 shift-add engine that stalls the pipeline
// while it iterates and returns the low XLEN bits of the product.
module ex_mul_seq #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_valid,
  input  logic            EX_brn,
  input  logic [3:0]      EX_alu_op,
  input  logic [XLEN-1:0] EX_a,
  input  logic [XLEN-1:0] EX_b,
  input  logic            EX_flush,
  output logic            EX_stall,
  output logic            EX_mul_done,
  output logic [XLEN-1:0] EX_mul_out
);

  localparam int unsigned CW     = $clog2(XLEN) + 1;
  localparam logic [3:0]  OP_MUL = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] a_r, b_r, acc;
  logic [XLEN-1:0] b_shift;
  logic [CW-1:0]   cnt;
  logic            start;
  logic            last_step;

  // rst_n gates start so EX_stall drops the instant reset asserts, even with a mul in EX.
  assign start = rst_n & EX_valid & ~EX_brn & (EX_alu_op == OP_MUL) & ~EX_flush &
                 (state == IDLE);

  assign b_shift   = b_r >> 1;
  assign last_step = (cnt == CW'(XLEN - 1)) || (EARLY_OUT && (b_shift == '0));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = BUSY;
      BUSY: begin
        if (EX_flush)       state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    EX_stall    = start | (state == BUSY);
    EX_mul_done = (state == DONE) & ~EX_flush;
  end

  assign EX_mul_out = acc;

  // Shift-add datapath; a flushed BUSY cycle leaves the accumulator untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      a_r <= EX_a;
      b_r <= EX_b;
      acc <= '0;
      cnt <= '0;
    end else if (state == BUSY && !EX_flush) begin
      if (b_r[0]) acc <= acc + a_r;
      a_r <= a_r << 1;
      b_r <= b_shift;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mul_seq.sv
// Self-checking bench for ex_mul_seq: fixed-latency and early-out instances checked
// against an arithmetic product/latency model.
module tb_ex_mul_seq;

  localparam int unsigned XLEN   = 32;
  localparam logic [3:0]  OP_MUL = 4'b1011;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            EX_valid, e_valid, EX_brn, EX_flush;
  logic [3:0]      EX_alu_op;
  logic [XLEN-1:0] EX_a, EX_b;
  logic            stall, done, e_stall, e_done;
  logic [XLEN-1:0] out, e_out;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_mul_seq #(.XLEN(XLEN), .EARLY_OUT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .EX_valid(EX_valid), .EX_brn(EX_brn),
    .EX_alu_op(EX_alu_op), .EX_a(EX_a), .EX_b(EX_b), .EX_flush(EX_flush),
    .EX_stall(stall), .EX_mul_done(done), .EX_mul_out(out)
  );

  ex_mul_seq #(.XLEN(XLEN), .EARLY_OUT(1'b1)) dut_eo (
    .clk(clk), .rst_n(rst_n), .EX_valid(e_valid), .EX_brn(EX_brn),
    .EX_alu_op(EX_alu_op), .EX_a(EX_a), .EX_b(EX_b), .EX_flush(EX_flush),
    .EX_stall(e_stall), .EX_mul_done(e_done), .EX_mul_out(e_out)
  );

  function automatic logic [XLEN-1:0] ref_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    return p[XLEN-1:0];
  endfunction

  task automatic idle_inputs();
    EX_valid = 1'b0; e_valid = 1'b0; EX_brn = 1'b0; EX_flush = 1'b0;
    EX_alu_op = 4'b0000; EX_a = '0; EX_b = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issues one multiply on the fixed-latency instance; returns positioned in the DONE cycle.
  task automatic do_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input string tag,
                        output int unsigned done_cyc);
    int unsigned     stalls = 0, lat = 0;
    bit              seen = 0;
    logic [XLEN-1:0] exp, res;
    exp = ref_mul(a, b);
    res = '0;
    done_cyc = 0;
    tick();
    EX_valid = 1'b1; EX_brn = 1'b0; EX_flush = 1'b0; EX_alu_op = OP_MUL; EX_a = a; EX_b = b;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin seen = 1; lat = i; res = out; done_cyc = cyc; end
      if (!seen) tick();
    end
    n_chk++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL %s_timeout: no done within 100 cycles", tag); end
    n_chk++;
    if (lat !== XLEN + 1) begin n_fail++; $display("FAIL %s_latency: got %0d, expected %0d", tag, lat, XLEN + 1); end
    n_chk++;
    if (stalls !== XLEN + 1) begin n_fail++; $display("FAIL %s_stall_cycles: got %0d, expected %0d", tag, stalls, XLEN + 1); end
    n_chk++;
    if (res !== exp) begin n_fail++; $display("FAIL %s_result: got %h, expected %h", tag, res, exp); end
  endtask

  task automatic post_idle(input logic [XLEN-1:0] exp, input string tag);
    int unsigned bad = 0;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (stall !== 1'b0 || done !== 1'b0 || out !== exp) bad++;
      tick();
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL %s_after_done: %0d bad cycles (out=%h, expected %h), expected 0", tag, bad, out, exp); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({stall, done, out, e_stall, e_done, e_out} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: stall=%b done=%b out=%h, expected all 0", stall, done, out);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int unsigned d;
    do_mul(32'd6, 32'd7, "mul_6x7", d);
    n_chk++;
    if (out !== 32'd42) begin n_fail++; $display("FAIL mul_6x7_literal: got %0d, expected 42", out); end
    post_idle(32'd42, "mul_6x7");
  endtask

  task automatic test_wrap();
    int unsigned d;
    do_mul(32'hFFFF_FFFF, 32'd2, "wrap_ffff", d);
    n_chk++;
    if (out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_ffff_literal: got %h, expected fffffffe", out); end
    post_idle(32'hFFFF_FFFE, "wrap_ffff");
    do_mul(32'h8000_0000, 32'h8000_0000, "wrap_msb", d);
    post_idle('0, "wrap_msb");
  endtask

  task automatic test_random();
    int unsigned     d;
    logic [XLEN-1:0] a, b;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = $urandom;
      do_mul(a, b, "rand", d);
      post_idle(ref_mul(a, b), "rand");
    end
  endtask

  task automatic test_back_to_back();
    int unsigned d1, d2;
    do_mul(32'd3, 32'd5, "b2b_first", d1);
    do_mul(32'd4, 32'd4, "b2b_second", d2);
    n_chk++;
    if (d2 - d1 !== XLEN + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d, expected %0d", d2 - d1, XLEN + 2); end
    post_idle(32'd16, "b2b");
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] a, b, part;
    int unsigned     bad = 0;
    a = $urandom; b = $urandom | 32'h0000_0105;
    part = ref_mul(a, b & 32'h0000_000F);
    tick();
    EX_valid = 1'b1; EX_alu_op = OP_MUL; EX_a = a; EX_b = b;
    for (int i = 0; i < 5; i++) begin @(negedge clk); tick(); end
    EX_flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if (stall !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL flush_busy_cycle: stall=%b done=%b, expected 1 0", stall, done); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if (stall !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL flush_next_idle: stall=%b done=%b, expected 0 0", stall, done); end
    n_chk++;
    if (out !== part) begin n_fail++; $display("FAIL flush_out_kept: got %h, expected %h", out, part); end
    for (int i = 0; i < 40; i++) begin
      tick(); @(negedge clk);
      if (done !== 1'b0 || stall !== 1'b0 || out !== part) bad++;
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL flush_quiet: %0d bad cycles, expected 0", bad); end
  endtask

  task automatic test_non_mul();
    int unsigned bad_add = 0, bad_brn = 0, bad_rand = 0, bad_fl = 0;
    logic [3:0]  op;
    for (int i = 0; i < 8; i++) begin
      tick();
      EX_valid = 1'b1; EX_brn = 1'b0; EX_alu_op = 4'b0000; EX_a = $urandom; EX_b = $urandom;
      @(negedge clk); if (stall !== 1'b0 || done !== 1'b0) bad_add++;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      EX_brn = 1'b1; EX_alu_op = OP_MUL; EX_a = $urandom; EX_b = $urandom;
      @(negedge clk); if (stall !== 1'b0 || done !== 1'b0) bad_brn++;
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      op = 4'($urandom_range(0, 15));
      if (op == OP_MUL) op = 4'b0111;
      EX_brn = 1'($urandom_range(0, 1)); EX_alu_op = op;
      @(negedge clk); if (stall !== 1'b0 || done !== 1'b0) bad_rand++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      EX_brn = 1'b0; EX_alu_op = OP_MUL; EX_flush = 1'b1;
      @(negedge clk); if (stall !== 1'b0 || done !== 1'b0) bad_fl++;
    end
    tick(); idle_inputs();
    @(negedge clk); if (stall !== 1'b0 || done !== 1'b0) bad_fl++;
    n_chk++;
    if (bad_add !== 0) begin n_fail++; $display("FAIL non_mul_add: %0d stall/done cycles, expected 0", bad_add); end
    n_chk++;
    if (bad_brn !== 0) begin n_fail++; $display("FAIL non_mul_branch: %0d stall/done cycles, expected 0", bad_brn); end
    n_chk++;
    if (bad_rand !== 0) begin n_fail++; $display("FAIL non_mul_random: %0d stall/done cycles, expected 0", bad_rand); end
    n_chk++;
    if (bad_fl !== 0) begin n_fail++; $display("FAIL flush_in_idle: %0d stall/done cycles, expected 0", bad_fl); end
  endtask

  task automatic test_reset_mid();
    int unsigned bad = 0;
    tick();
    EX_valid = 1'b1; EX_alu_op = OP_MUL; EX_a = $urandom | 32'h1; EX_b = $urandom | 32'h1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); tick(); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (stall !== 1'b0 || done !== 1'b0 || out !== '0) begin
      n_fail++; $display("FAIL reset_mid_busy: stall=%b done=%b out=%h, expected 0 0 0", stall, done, out);
    end
    idle_inputs();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(); @(negedge clk);
      if (done !== 1'b0 || stall !== 1'b0 || out !== '0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_no_partial: %0d bad cycles, expected 0", bad); end
  endtask

  task automatic test_early_out();
    logic [XLEN-1:0] as [4];
    logic [XLEN-1:0] bs [4];
    logic [XLEN-1:0] res;
    int unsigned     steps, lat;
    bit              seen;
    as[0] = $urandom; bs[0] = 32'd1;
    as[1] = $urandom; bs[1] = 32'd0;
    as[2] = $urandom; bs[2] = 32'($urandom_range(2, 1000));
    as[3] = $urandom; bs[3] = 32'h8000_0000;
    for (int k = 0; k < 4; k++) begin
      steps = 1;
      for (int j = 0; j < XLEN; j++) if (bs[k][j]) steps = j + 1;
      seen = 0; lat = 0; res = '0;
      tick();
      e_valid = 1'b1; EX_alu_op = OP_MUL; EX_a = as[k]; EX_b = bs[k];
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (e_done) begin seen = 1; lat = i; res = e_out; end
        if (!seen) tick();
      end
      n_chk++;
      if (seen !== 1'b1 || lat !== steps + 1) begin
        n_fail++; $display("FAIL early_latency_%0d: got %0d (seen=%b), expected %0d", k, lat, seen, steps + 1);
      end
      n_chk++;
      if (res !== ref_mul(as[k], bs[k])) begin
        n_fail++; $display("FAIL early_result_%0d: got %h, expected %h", k, res, ref_mul(as[k], bs[k]));
      end
      tick(); idle_inputs();
      @(negedge clk);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_back_to_back();
    test_flush();
    test_non_mul();
    test_reset_mid();
    test_early_out();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
